// File: rtl/tinyalu_requester.sv
`timescale 1ns/1ps
// tinyalu_requester: on-chip initiator for the TinyALU start/done handshake.
// Commands are queued in a small FIFO and issued one at a time. Each
// arithmetic result comes back on a valid/ready response port. A down-counting
// watchdog aborts a command whose ALU never raises done.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | alu_start low; pop the FIFO head when one is present
// ISSUE  | alu_start high, operands stable, until done or watchdog expiry
// NOP    | single alu_start cycle with op 000, no response
// ALURST | single alu_reset_n low cycle (rst_op, or cleanup after a timeout)
// RESP   | response held on rsp_* until rsp_ready
module tinyalu_requester #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    output logic        alu_reset_n,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(CMD_DEPTH);
    localparam logic [CW-1:0] TO_LOAD_C = CW'(TIMEOUT);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_NOP,
        S_ALURST,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    // Command FIFO: {op, a, b} per entry
    logic [18:0]   fifo_mem_q [CMD_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          cmd_ready_q;
    logic          push, pop;
    logic [2:0]    head_op;
    logic [7:0]    head_a, head_b;

    // Issue and response registers
    logic [7:0]    alu_a_q, alu_a_d;
    logic [7:0]    alu_b_q, alu_b_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          to_rsp_q, to_rsp_d;
    logic [15:0]   rsp_result_q, rsp_result_d;
    logic [2:0]    rsp_op_q, rsp_op_d;
    logic          rsp_err_q, rsp_err_d;

    assign push = cmd_valid && cmd_ready_q;
    assign {head_op, head_a, head_b} = fifo_mem_q[rd_ptr_q];

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO pointers, occupancy and registered ready (wrap relies on power-of-two depth)
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            cmd_ready_q <= (count_d != DEPTH_C);
        end
    end

    // Next-state, pop decision and datapath updates
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        to_cnt_d     = to_cnt_q;
        to_rsp_d     = to_rsp_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    alu_a_d  = head_a;
                    alu_b_d  = head_b;
                    to_cnt_d = TO_LOAD_C;
                    to_rsp_d = 1'b0;
                    case (head_op)
                        OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
                            alu_op_d = head_op;
                            state_d  = S_ISSUE;
                        end
                        OP_RST: begin
                            alu_op_d = OP_NOP;
                            state_d  = S_ALURST;
                        end
                        default: begin
                            // 000, 101 and 110 all present op 000 to the ALU
                            alu_op_d = OP_NOP;
                            state_d  = S_NOP;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                if (alu_done) begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    rsp_op_d     = alu_op_q;
                    state_d      = S_RESP;
                end else if (to_cnt_q == '0) begin
                    // Hung ALU: reset it before reporting the error
                    rsp_result_d = 16'h0000;
                    rsp_err_d    = 1'b1;
                    rsp_op_d     = alu_op_q;
                    to_rsp_d     = 1'b1;
                    state_d      = S_ALURST;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
            end
            S_NOP: begin
                state_d = S_IDLE;
            end
            S_ALURST: begin
                state_d = to_rsp_q ? S_RESP : S_IDLE;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            to_cnt_q     <= '0;
            to_rsp_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            to_cnt_q     <= to_cnt_d;
            to_rsp_q     <= to_rsp_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign alu_start   = (state_q == S_ISSUE) || (state_q == S_NOP);
    assign alu_reset_n = (state_q != S_ALURST);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_result  = rsp_result_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_tinyalu_requester.sv
`timescale 1ns/1ps
// Directed bench for tinyalu_requester with a behavioural TinyALU model.
module tb_tinyalu_requester;
    localparam int DEPTH = 4;
    localparam int TO    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_start, alu_reset_n;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic hang = 1'b0;
    int   model_lat = 0;

    int   start_cyc = 0, start_rises = 0, nop_cyc = 0, arst_cyc = 0, rsp_n = 0;
    logic start_prev = 1'b0;
    logic [15:0] got_res [64];
    logic [2:0]  got_op  [64];
    logic        got_err [64];

    tinyalu_requester #(.CMD_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_start(alu_start), .alu_reset_n(alu_reset_n),
        .alu_done(alu_done), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b001:  return {8'h00, a} + {8'h00, b};
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // TinyALU model: mul takes 3 cycles, other ops 1; hang suppresses done
    always @(posedge clk) begin
        if (reset || !alu_reset_n) begin
            model_lat  <= 0;
            alu_done   <= 1'b0;
            alu_result <= 16'h0000;
        end else if (alu_done) begin
            alu_done  <= 1'b0;
            model_lat <= 0;
        end else if (alu_start && alu_op != 3'b000 && !hang) begin
            if (model_lat + 1 >= ((alu_op == 3'b100) ? 3 : 1)) begin
                alu_done   <= 1'b1;
                alu_result <= alu_calc(alu_op, alu_a, alu_b);
                model_lat  <= 0;
            end else begin
                model_lat <= model_lat + 1;
            end
        end else begin
            model_lat <= 0;
        end
    end

    // Per-cycle monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (alu_start === 1'b1) start_cyc++;
        if (alu_start === 1'b1 && start_prev !== 1'b1) start_rises++;
        if (alu_start === 1'b1 && alu_op === 3'b000) nop_cyc++;
        if (alu_reset_n === 1'b0) arst_cyc++;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1 && rsp_n < 64) begin
            got_res[rsp_n] = rsp_result;
            got_op[rsp_n]  = rsp_op;
            got_err[rsp_n] = rsp_err;
            rsp_n++;
        end
        start_prev = alu_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        while (cmd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL push_accept got cmd_ready=%b exp 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp_count(input int target, output bit timed_out);
        int n;
        n = 0;
        while (rsp_n < target && n < 300) begin
            tick();
            n++;
        end
        timed_out = (rsp_n < target);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if ({cmd_ready, alu_start, alu_reset_n, rsp_valid} !== 4'b1010) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b exp 1010", {cmd_ready, alu_start, alu_reset_n, rsp_valid});
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_op} !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_alu_fields got %h exp 0", {alu_a, alu_b, alu_op});
        end
        n_cmp++;
        if ({rsp_result, rsp_op, rsp_err} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_rsp_fields got %h exp 0", {rsp_result, rsp_op, rsp_err});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        int b_rsp, b_rise;
        rsp_ready = 1'b1;
        b_rsp  = rsp_n;
        b_rise = start_rises;
        push_cmd(3'b001, 8'hFF, 8'h01);
        n_cmp++;
        if (alu_start !== 1'b0) begin
            n_bad++;
            $display("FAIL add_start_early got %b exp 0", alu_start);
        end
        tick();
        n_cmp++;
        if ({alu_start, alu_a, alu_b, alu_op} !== {1'b1, 8'hFF, 8'h01, 3'b001}) begin
            n_bad++;
            $display("FAIL add_issue got %h exp %h", {alu_start, alu_a, alu_b, alu_op}, {1'b1, 8'hFF, 8'h01, 3'b001});
        end
        tick();
        tick();
        n_cmp++;
        if ({rsp_valid, alu_start} !== 2'b10) begin
            n_bad++;
            $display("FAIL add_done_to_rsp got valid,start=%b exp 10", {rsp_valid, alu_start});
        end
        n_cmp++;
        if ({rsp_result, rsp_op, rsp_err} !== {16'h0100, 3'b001, 1'b0}) begin
            n_bad++;
            $display("FAIL add_rsp got %h/%b/%b exp 0100/001/0", rsp_result, rsp_op, rsp_err);
        end
        tick(); tick();
        n_cmp++;
        if (rsp_n - b_rsp !== 1 || start_rises - b_rise !== 1) begin
            n_bad++;
            $display("FAIL add_counts got rsp=%0d starts=%0d exp 1 1", rsp_n - b_rsp, start_rises - b_rise);
        end
    endtask

    task automatic test_back_to_back();
        int b_rsp, b_rise, b_cyc;
        bit tmo;
        logic [15:0] exp_res [3];
        logic [2:0]  exp_op  [3];
        exp_res = '{16'h0030, 16'h00CC, 16'hFE01};
        exp_op  = '{3'b010, 3'b011, 3'b100};
        rsp_ready = 1'b1;
        b_rsp  = rsp_n;
        b_rise = start_rises;
        b_cyc  = start_cyc;
        push_cmd(3'b010, 8'hF0, 8'h3C);
        push_cmd(3'b011, 8'hF0, 8'h3C);
        push_cmd(3'b100, 8'hFF, 8'hFF);
        wait_rsp_count(b_rsp + 3, tmo);
        n_cmp++;
        if (tmo) begin
            n_bad++;
            $display("FAIL b2b_timeout got %0d responses exp 3", rsp_n - b_rsp);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if ({got_res[b_rsp+i], got_op[b_rsp+i], got_err[b_rsp+i]} !== {exp_res[i], exp_op[i], 1'b0}) begin
                    n_bad++;
                    $display("FAIL b2b_rsp%0d got %h/%b/%b exp %h/%b/0", i, got_res[b_rsp+i], got_op[b_rsp+i], got_err[b_rsp+i], exp_res[i], exp_op[i]);
                end
            end
        end
        tick(); tick();
        n_cmp++;
        if (start_rises - b_rise !== 3 || start_cyc - b_cyc !== 8) begin
            n_bad++;
            $display("FAIL b2b_start got rises=%0d cycles=%0d exp 3 8", start_rises - b_rise, start_cyc - b_cyc);
        end
    endtask

    task automatic test_nop_rst();
        int b_rsp, b_nop, b_arst, b_cyc;
        rsp_ready = 1'b1;
        b_rsp  = rsp_n;
        b_nop  = nop_cyc;
        b_arst = arst_cyc;
        b_cyc  = start_cyc;
        push_cmd(3'b000, 8'h11, 8'h22);
        push_cmd(3'b111, 8'h33, 8'h44);
        push_cmd(3'b101, 8'h55, 8'h66);
        for (int i = 0; i < 12; i++) tick();
        n_cmp++;
        if (rsp_n - b_rsp !== 0) begin
            n_bad++;
            $display("FAIL nop_rsp_count got %0d exp 0", rsp_n - b_rsp);
        end
        n_cmp++;
        if (nop_cyc - b_nop !== 2 || start_cyc - b_cyc !== 2) begin
            n_bad++;
            $display("FAIL nop_start got op0=%0d total=%0d exp 2 2", nop_cyc - b_nop, start_cyc - b_cyc);
        end
        n_cmp++;
        if (arst_cyc - b_arst !== 1) begin
            n_bad++;
            $display("FAIL rstop_pulse got %0d exp 1", arst_cyc - b_arst);
        end
    endtask

    task automatic test_backpressure();
        int b_rsp, b_rise, dev;
        bit tmo;
        logic [15:0] exp_res [5];
        exp_res = '{16'h0003, 16'h0007, 16'h000B, 16'h000F, 16'h0013};
        rsp_ready = 1'b0;
        b_rsp  = rsp_n;
        b_rise = start_rises;
        for (int i = 0; i < 5; i++) begin
            push_cmd(3'b001, 8'(2*i + 1), 8'(2*i + 2));
        end
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_cmd_ready_full got %b exp 0", cmd_ready);
        end
        dev = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid !== 1'b1 || rsp_result !== 16'h0003 || rsp_op !== 3'b001 ||
                alu_start !== 1'b0 || cmd_ready !== 1'b0) dev++;
            tick();
        end
        n_cmp++;
        if (dev !== 0) begin
            n_bad++;
            $display("FAIL bp_hold got %0d unstable cycles exp 0", dev);
        end
        n_cmp++;
        if (start_rises - b_rise !== 1 || rsp_n - b_rsp !== 0) begin
            n_bad++;
            $display("FAIL bp_stall got rises=%0d rsp=%0d exp 1 0", start_rises - b_rise, rsp_n - b_rsp);
        end
        rsp_ready = 1'b1;
        wait_rsp_count(b_rsp + 5, tmo);
        n_cmp++;
        if (tmo) begin
            n_bad++;
            $display("FAIL bp_timeout got %0d responses exp 5", rsp_n - b_rsp);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (got_res[b_rsp+i] !== exp_res[i]) begin
                    n_bad++;
                    $display("FAIL bp_rsp%0d got %h exp %h", i, got_res[b_rsp+i], exp_res[i]);
                end
            end
        end
        tick(); tick();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_cmd_ready_drain got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_timeout();
        int b_rsp, b_arst, k, d;
        bit tmo;
        rsp_ready = 1'b1;
        hang   = 1'b1;
        b_rsp  = rsp_n;
        b_arst = arst_cyc;
        push_cmd(3'b001, 8'h12, 8'h34);
        push_cmd(3'b001, 8'h20, 8'h22);
        n_cmp++;
        if (alu_start !== 1'b1) begin
            n_bad++;
            $display("FAIL to_issue got %b exp 1", alu_start);
        end
        k = 0;
        while (alu_start === 1'b1 && k < 40) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k < TO) begin
            n_bad++;
            $display("FAIL to_start_len got %0d exp >= %0d", k, TO);
        end
        n_cmp++;
        if ({alu_reset_n, alu_start} !== 2'b00) begin
            n_bad++;
            $display("FAIL to_alurst got reset_n,start=%b exp 00", {alu_reset_n, alu_start});
        end
        hang = 1'b0;
        d = k;
        while (rsp_valid !== 1'b1 && d < 40) begin
            tick();
            d++;
        end
        n_cmp++;
        if (d !== TO + 2) begin
            n_bad++;
            $display("FAIL to_rsp_delay got %0d exp %0d", d, TO + 2);
        end
        n_cmp++;
        if ({rsp_result, rsp_op, rsp_err} !== {16'h0000, 3'b001, 1'b1}) begin
            n_bad++;
            $display("FAIL to_rsp got %h/%b/%b exp 0000/001/1", rsp_result, rsp_op, rsp_err);
        end
        wait_rsp_count(b_rsp + 2, tmo);
        n_cmp++;
        if (tmo || got_res[b_rsp+1] !== 16'h0042 || got_err[b_rsp+1] !== 1'b0) begin
            n_bad++;
            $display("FAIL to_next_add got n=%0d res=%h err=%b exp 2 0042 0", rsp_n - b_rsp, got_res[b_rsp+1], got_err[b_rsp+1]);
        end
        n_cmp++;
        if (arst_cyc - b_arst !== 1) begin
            n_bad++;
            $display("FAIL to_reset_pulses got %0d exp 1", arst_cyc - b_arst);
        end
    endtask

    task automatic test_reset_mid();
        int b_rsp, b_rise, b_arst;
        rsp_ready = 1'b1;
        hang   = 1'b1;
        b_arst = arst_cyc;
        push_cmd(3'b100, 8'h0F, 8'h0F);
        push_cmd(3'b001, 8'h01, 8'h01);
        push_cmd(3'b011, 8'h02, 8'h02);
        n_cmp++;
        if ({alu_start, alu_op} !== 4'b1100) begin
            n_bad++;
            $display("FAIL rm_in_issue got %b exp 1100", {alu_start, alu_op});
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({alu_start, rsp_valid, cmd_ready, alu_reset_n} !== 4'b0011) begin
            n_bad++;
            $display("FAIL rm_outputs got %b exp 0011", {alu_start, rsp_valid, cmd_ready, alu_reset_n});
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_op, rsp_result, rsp_op, rsp_err} !== 39'h0) begin
            n_bad++;
            $display("FAIL rm_fields got %h exp 0", {alu_a, alu_b, alu_op, rsp_result, rsp_op, rsp_err});
        end
        reset = 1'b0;
        hang  = 1'b0;
        b_rsp  = rsp_n;
        b_rise = start_rises;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (rsp_n - b_rsp !== 0 || start_rises - b_rise !== 0 || arst_cyc - b_arst !== 0) begin
            n_bad++;
            $display("FAIL rm_after got rsp=%0d starts=%0d arst=%0d exp 0 0 0", rsp_n - b_rsp, start_rises - b_rise, arst_cyc - b_arst);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_op    = 3'b000;
        rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_nop_rst();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
